// File: rtl/mem_ctrl.sv
// Single-port memory access controller: one request at a time, IDLE -> ACCESS -> (LATCH) -> DONE.
// Define MEM_CTRL_WAIT_EN to insert WAIT extra cycles (state WAITS) before DONE.
module mem_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ADDR_SIZE = 10,
    parameter int WAIT      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic                 ack,
    output logic [WIDTH-1:0]     rdata,
    output logic                 busy,
    output logic                 mem_cs,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_ra,
    output logic [WIDTH-1:0]     mem_din,
    input  logic [WIDTH-1:0]     mem_dout,
    output logic [2:0]           o_dbg_state
);

    if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
        $error("mem_ctrl: WAIT must be within 0..15");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        LATCH  = 3'd2,
`ifdef MEM_CTRL_WAIT_EN
        WAITS  = 3'd4,
`endif
        DONE   = 3'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_we;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [WIDTH-1:0]       r_wdata;
    logic [WIDTH-1:0]       r_rdata;
    state_t                 w_after_data;

`ifdef MEM_CTRL_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT);
    logic [3:0] r_wcnt;

    // Counter reloads outside WAITS so it holds WAIT on entry and expires at 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wcnt <= 4'd0;
        end else if (r_state == WAITS) begin
            r_wcnt <= r_wcnt - 4'd1;
        end else begin
            r_wcnt <= WAIT_LOAD;
        end
    end

    assign w_after_data = (WAIT_LOAD != 4'd0) ? WAITS : DONE;
`else
    assign w_after_data = DONE;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == LATCH) begin
                r_rdata <= mem_dout;
            end
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:   w_next = req ? ACCESS : IDLE;
            ACCESS: w_next = r_we ? w_after_data : LATCH;
            LATCH:  w_next = w_after_data;
`ifdef MEM_CTRL_WAIT_EN
            WAITS:  w_next = (r_wcnt <= 4'd1) ? DONE : WAITS;
`endif
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are gated by reset so an access in flight never touches memory.
    always_comb begin
        mem_cs      = (r_state == ACCESS) && reset;
        mem_wen     = mem_cs && r_we;
        mem_ra      = r_addr;
        mem_din     = r_wdata;
        ack         = (r_state == DONE) && reset;
        busy        = (r_state != IDLE);
        rdata       = r_rdata;
        o_dbg_state = r_state;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, address width in bits.
REQ-003 SHALL have parameter WAIT, default 2, extra wait cycles (0..15), used only when MEM_CTRL_WAIT_EN is defined.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req  input  1  requester access request, level.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port addr  input  ADDR_SIZE  access address.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  WIDTH  registered read data.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port mem_cs  output  1  memory chip select.
REQ-014 SHALL have port mem_wen  output  1  memory write enable.
REQ-015 SHALL have port mem_ra  output  ADDR_SIZE  memory address.
REQ-016 SHALL have port mem_din  output  WIDTH  memory write data.
REQ-017 SHALL have port mem_dout  input  WIDTH  memory read data, valid one cycle after a selected read.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, LATCH, WAITS, DONE.
REQ-019 IDLE with req=1 SHALL latch addr, we and wdata, then go to ACCESS; IDLE with req=0 SHALL stay in IDLE.
REQ-020 In ACCESS, mem_cs SHALL be 1, mem_wen SHALL equal latched we, and mem_ra/mem_din SHALL equal latched values; mem_cs SHALL be 0 in every other state.
REQ-021 ACCESS SHALL go to LATCH on a read and to DONE on a write (or to WAITS when enabled and WAIT>0).
REQ-022 LATCH SHALL register mem_dout into rdata at the end of the cycle, then go to DONE (or to WAITS when enabled and WAIT>0).
REQ-023 In DONE, ack SHALL be 1 for exactly one cycle; DONE SHALL always go to IDLE.
REQ-024 Latency from the req-sampling edge to ack SHALL be 3 cycles for reads and 2 for writes, plus WAIT when wait states are enabled.
REQ-025 req SHALL be ignored outside IDLE; a requester holding req through the IDLE cycle after ack SHALL start a new access.
REQ-026 rdata SHALL hold its value until the next read LATCH or reset; writes SHALL NOT alter rdata.
REQ-027 mem_cs SHALL be gated by reset (mem_cs=0 while reset=0) so no write reaches memory during reset.
REQ-028 mem_wen SHALL be 0 whenever mem_cs is 0.

Reset
REQ-029 reset=0 at a clock edge SHALL force the state to IDLE, clear the wait counter and set rdata=0, from any state including mid-access.
REQ-030 After reset: ack=0, busy=0, mem_cs=0, mem_wen=0; no ack SHALL be issued for an aborted access.

Configuration
REQ-031 With macro MEM_CTRL_WAIT_EN defined, the WAITS state SHALL run a 4-bit down-counter loaded with WAIT and go to DONE when it expires, adding exactly WAIT cycles; WAIT=0 SHALL skip WAITS.
REQ-032 Without MEM_CTRL_WAIT_EN, the WAITS state and counter SHALL NOT exist, WAIT SHALL be ignored, and latencies SHALL be those of REQ-024.

Verification
REQ-033 Write 0xA5 to addr 0x012 (no macro) -> mem_cs=1 and mem_wen=1 with mem_ra=0x012 and mem_din=0xA5 in cycle +1; ack in cycle +2.
REQ-034 Read addr 0x012 after REQ-033 -> mem_cs=1 and mem_wen=0 in cycle +1; ack=1 and rdata=0xA5 in cycle +3; rdata stays 0xA5 through a following write of 0x3C.
REQ-035 MEM_CTRL_WAIT_EN, WAIT=2: read -> ack in cycle +5; WAIT=0 -> ack in cycle +3.
REQ-036 req held high continuously -> accesses repeat with one IDLE cycle between each ack and the next ACCESS; req toggled during ACCESS has no effect.
REQ-037 reset=0 asserted during the ACCESS cycle of a write to 0x3FF -> mem_cs=0 that cycle, memory at 0x3FF unchanged, no ack, rdata=0, busy=0 on the next cycle.
